// File: rtl/cache_types_pkg.sv
// Shared cache types: instruction-cache FSM states, frame layout and geometry helpers.
package cache_types_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_t;

  localparam int ICACHE_NFRAMES = 16;
  localparam int ICACHE_IDXW    = $clog2(ICACHE_NFRAMES);
  localparam int ICACHE_TAGW    = 30 - ICACHE_IDXW;

  typedef struct packed {
    logic                   valid;
    logic [ICACHE_TAGW-1:0] tag;
    logic [31:0]            data;
  } icache_frame_t;

  // Tag width for an arbitrary frame count: 32 address bits minus byte offset and index.
  function automatic int icache_tagw(input int nframes);
    return 30 - $clog2(nframes);
  endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with same-cycle hits and a single-word
// blocking fill toward the memory controller.
module icache
  import cache_types_pkg::*;
#(
  parameter int NFRAMES = ICACHE_NFRAMES
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDXW = $clog2(NFRAMES);
  localparam int TAGW = icache_tagw(NFRAMES);

  icache_state_t state_q;
  logic [31:0]   miss_addr_q;

  logic [NFRAMES-1:0] valid_vec;
  logic [TAGW-1:0]    tag_arr  [NFRAMES];
  logic [31:0]        data_arr [NFRAMES];

  logic [IDXW-1:0] req_idx;
  logic [TAGW-1:0] req_tag;
  logic [IDXW-1:0] fill_idx;
  logic [TAGW-1:0] fill_tag;
  logic            hit;
  logic            fill_done;
  logic            unused_addr_bits;

  assign req_idx  = imemaddr[IDXW+1:2];
  assign req_tag  = imemaddr[31:IDXW+2];
  assign fill_idx = miss_addr_q[IDXW+1:2];
  assign fill_tag = miss_addr_q[31:IDXW+2];
  assign unused_addr_bits = ^{imemaddr[1:0], miss_addr_q[1:0]};

  assign hit       = imemREN & valid_vec[req_idx] & (tag_arr[req_idx] == req_tag);
  assign fill_done = (state_q == MISS) & ~iwait;

  // A lookup only counts as a hit while idle; a fill in flight masks it.
  assign ihit     = hit & (state_q == IDLE);
  assign imemload = hit ? data_arr[req_idx] : 32'h0;
  assign iREN     = (state_q == MISS);
  assign iaddr    = (state_q == MISS) ? miss_addr_q : 32'h0;

  genvar gi;
  generate
    for (gi = 0; gi < NFRAMES; gi++) begin : g_frame
      localparam logic [IDXW-1:0] FRAME_IDX = IDXW'(gi);

      logic            frame_valid_q;
      logic [TAGW-1:0] frame_tag_q;
      logic [31:0]     frame_data_q;
      logic            frame_we;

      assign frame_we = fill_done & (fill_idx == FRAME_IDX);

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          frame_valid_q <= 1'b0;
        end else if (frame_we) begin
          frame_valid_q <= 1'b1;
        end
      end

      // Tag and data carry no reset: they are meaningless until valid is set.
      always_ff @(posedge CLK) begin
        if (frame_we) begin
          frame_tag_q  <= fill_tag;
          frame_data_q <= iload;
        end
      end

      assign valid_vec[gi] = frame_valid_q;
      assign tag_arr[gi]   = frame_tag_q;
      assign data_arr[gi]  = frame_data_q;
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (imemREN && !hit) begin
            miss_addr_q <= imemaddr;
            state_q     <= MISS;
          end
        end
        MISS: begin
          if (!iwait) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed test-plan scenarios followed by randomized
// fetch/wait/reset traffic, all compared against a frame-level reference model.
module tb_icache;

  logic        clk;
  logic        nrst;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  icache #(.NFRAMES(16)) dut (
    .CLK      (clk),
    .nRST     (nrst),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ren_cnt = 0;

  // Reference model: one entry per frame plus a pending-fill flag and address.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  bit          m_busy;
  logic [31:0] m_addr;
  logic [31:0] mem_ov [logic [31:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem_ov.exists(a)) return mem_ov[a];
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_busy = 1'b0;
    m_addr = 32'h0;
  endtask

  // One clock: compare outputs at the falling edge, then advance the model with the edge.
  task automatic step(input string name, output bit exp_hit);
    int          idx;
    logic [25:0] tg;
    logic [31:0] exp_load;
    idx = int'(imemaddr[5:2]);
    tg  = imemaddr[31:6];
    iload = m_busy ? memval(m_addr) : $urandom;
    @(negedge clk);
    if (m_busy) begin
      exp_hit = 1'b0;
      check({name, ".ihit"}, {31'b0, ihit}, 32'd0);
      check({name, ".iREN"}, {31'b0, iREN}, 32'd1);
      check({name, ".iaddr"}, iaddr, m_addr);
    end else begin
      exp_hit  = imemREN && m_valid[idx] && (m_tag[idx] == tg);
      exp_load = exp_hit ? m_data[idx] : 32'h0;
      check({name, ".ihit"}, {31'b0, ihit}, {31'b0, exp_hit});
      check({name, ".imemload"}, imemload, exp_load);
      check({name, ".iREN"}, {31'b0, iREN}, 32'd0);
      check({name, ".iaddr"}, iaddr, 32'h0);
    end
    if (iREN === 1'b1) ren_cnt++;
    @(posedge clk);
    if (!m_busy) begin
      if (imemREN && !exp_hit) begin
        m_busy = 1'b1;
        m_addr = imemaddr;
      end
    end else if (!iwait) begin
      m_valid[int'(m_addr[5:2])] = 1'b1;
      m_tag[int'(m_addr[5:2])]   = m_addr[31:6];
      m_data[int'(m_addr[5:2])]  = memval(m_addr);
      m_busy = 1'b0;
    end
    #1;
  endtask

  // Hold a fetch until it hits; returns the cycle on which ihit was expected.
  task automatic fetch(input logic [31:0] a, input int w, input string name, output int hit_cyc);
    int wcnt = 0;
    bit h;
    hit_cyc = -1;
    imemREN  = 1'b1;
    imemaddr = a;
    for (int c = 0; c < 30; c++) begin
      iwait = m_busy && (wcnt < w);
      if (m_busy) wcnt++;
      step(name, h);
      if (h) begin
        hit_cyc = c;
        break;
      end
    end
    if (hit_cyc < 0) check({name, ".timeout"}, 32'd1, 32'd0);
    $display("fetch %-10s addr=%h waits=%0d hit_cycle=%0d", name, a, w, hit_cyc);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    check("rst.ihit", {31'b0, ihit}, 32'd0);
    check("rst.iREN", {31'b0, iREN}, 32'd0);
    check("rst.iaddr", iaddr, 32'h0);
    check("rst.imemload", imemload, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    int  hc;
    bit  h;
    nrst     = 1'b1;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b0;
    iload    = 32'h0;
    mem_ov[32'h0]  = 32'h3C01_0004;
    mem_ov[32'h4]  = 32'h3421_0008;
    mem_ov[32'h40] = 32'hDEAD_BEEF;
    model_reset();
    #2;
    do_reset();
    @(posedge clk);
    #1;

    // Cold miss, then hit.
    fetch(32'h0, 0, "cold", hc);
    check("cold.latency", hc, 32'd2);
    fetch(32'h4, 0, "second", hc);
    check("second.latency", hc, 32'd2);
    ren_cnt = 0;
    fetch(32'h0, 0, "hit0", hc);
    check("hit0.latency", hc, 32'd0);
    check("hit0.data", imemload, 32'h3C01_0004);
    check("hit0.no_ren", ren_cnt, 32'd0);

    // Conflict eviction at index 0.
    fetch(32'h40, 0, "evict", hc);
    check("evict.latency", hc, 32'd2);
    fetch(32'h40, 0, "evict_hit", hc);
    check("evict_hit.latency", hc, 32'd0);
    fetch(32'h0, 0, "refill0", hc);
    check("refill0.latency", hc, 32'd2);

    // Five wait states.
    ren_cnt = 0;
    fetch(32'hC, 5, "wait5", hc);
    check("wait5.latency", hc, 32'd7);
    check("wait5.ren_cycles", ren_cnt, 32'd6);

    // Address change while the fill is pending.
    imemREN  = 1'b1;
    imemaddr = 32'h8;
    iwait    = 1'b0;
    step("mid.c0", h);
    imemaddr = 32'h100;
    iwait    = 1'b1;
    for (int i = 0; i < 3; i++) step("mid.wait", h);
    iwait = 1'b0;
    step("mid.fill", h);
    fetch(32'h100, 0, "mid.new", hc);
    check("mid.new.latency", hc, 32'd2);
    fetch(32'h8, 0, "mid.old", hc);
    check("mid.old.latency", hc, 32'd0);

    // Reset while a fill is pending.
    imemaddr = 32'h20;
    iwait    = 1'b0;
    step("rstmiss.c0", h);
    iwait = 1'b1;
    step("rstmiss.c1", h);
    do_reset();
    fetch(32'h20, 0, "rstmiss.re", hc);
    check("rstmiss.latency", hc, 32'd2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      imemREN  = ($urandom_range(0, 3) != 0);
      imemaddr = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      iwait    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      else step("rand", h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache: the responder on the instruction side of `datapath_cache_if`, plus the instruction port of `caches_if` toward the memory controller. It accepts the pipeline's fetch requests (`imemREN`/`imemaddr`) and answers with `ihit`/`imemload`. Hits complete in the same cycle. On a miss it runs a single-word fill through `iREN`/`iaddr`/`iwait`/`iload`. It sits between `datapath` and the memory controller inside the cache wrapper.

## Interface
- `NFRAMES`, default 16: number of one-word frames; must be a power of 2. IDXW = log2(NFRAMES).
- `CLK` in 1: rising-edge clock.
- `nRST` in 1: asynchronous, active-low reset.
- `dcif.imemREN` in 1: fetch request from the datapath.
- `dcif.imemaddr` in 32: fetch byte address, word aligned.
- `dcif.ihit` out 1: hit; `imemload` is valid this cycle.
- `dcif.imemload` out 32: instruction word.
- `cif.iREN` out 1: fill request to the memory controller.
- `cif.iaddr` out 32: fill address.
- `cif.iwait` in 1: memory busy. Low means `iload` is valid this cycle.
- `cif.iload` in 32: fill data.
- Ports are grouped through the `datapath_cache_if.icache` and `caches_if.icache` modports.

## Operation
- Address split: [1:0] byte offset (ignored); [IDXW+1:2] index; [31:IDXW+2] tag (26 bits at the default).
- Frame: {valid, tag, data}. Reset clears all valid bits. Tag and data are don't-care after reset.
- hit = imemREN & frame[index].valid & (frame[index].tag == addr tag). Combinational.
- `ihit` = hit, and only when state is IDLE. `imemload` = frame[index].data when hit, else 0.
- FSM states: IDLE, MISS.
  - IDLE: if imemREN & ~hit, latch `imemaddr` into `miss_addr` and go to MISS. Otherwise stay.
  - MISS: `iREN`=1 and `iaddr`=`miss_addr`. While iwait=1, stay. When iwait=0, write frame[miss_addr index] = {1, miss_addr tag, iload} and go to IDLE.
- `iREN`=0 and `iaddr`=0 in IDLE.
- A fill in progress is never aborted. If `imemaddr` or `imemREN` changes during MISS, the fill still completes to `miss_addr`. The new address is evaluated in IDLE on the next cycle.
- `ihit` is forced to 0 in MISS even if the current address would hit. The fill is the only frame write.
- A conflict miss overwrites the frame unconditionally. There is no dirty state and no write path.
- `halt` and the data side have no effect on this block.

## Timing
- Reset (async, nRST=0):
  - state=IDLE, all valid=0.
  - Outputs: ihit=0, imemload=0, iREN=0, iaddr=0.
- Hit latency: 0 cycles. `ihit`/`imemload` are combinational from `imemaddr` in IDLE.
- Miss latency, with cycle 0 = request seen in IDLE:
  - Cycle 0: ihit=0.
  - Cycle 1: iREN=1.
  - The fill writes on the first edge where iwait=0, at cycle 1+W for W wait cycles.
  - ihit=1 on cycle 2+W if the address is unchanged.
- Reset asserted during MISS: the fill is dropped, state returns to IDLE, and valid bits clear. A later fetch misses again.
- Back-to-back misses: at least one IDLE cycle separates fills. iREN drops for one cycle.
- A same-index fetch immediately after a fill to that index hits in IDLE.

## Structure
- Shared `cache_types_pkg`:
  - `icache_state_t` {IDLE, MISS}.
  - `icache_frame_t` packed {valid, tag, data}.
  - `ICACHE_TAGW` / `ICACHE_IDXW` localparam-derivable constants.
- Single module `icache`: frame array, FSM register, `miss_addr` register, comb hit/output logic.
- No sub-module. The frame array is a flip-flop array written only in MISS.

## Test plan
- Cold miss:
  - Stimulus: reset, then imemREN=1, imemaddr=0x0. Memory drives iwait=0, iload=0x3C010004 on cycle 1.
  - Required: cycle 1 iREN=1, iaddr=0x0; cycle 2 ihit=1, imemload=0x3C010004.
- Hit:
  - Stimulus: after the cold miss, addr 0x4 (miss, fill 0x34210008), then addr 0x0 again.
  - Required: ihit=1 in the same cycle with 0x3C010004; iREN stays 0.
- Conflict eviction (NFRAMES=16):
  - Stimulus: addr 0x40 (index 0, tag 1), fill 0xDEADBEEF, then addr 0x0.
  - Required: 0x40 hits with 0xDEADBEEF; 0x0 misses and refills.
- Wait states:
  - Stimulus: iwait=1 for 5 cycles on a miss.
  - Required: iREN=1 and iaddr stable for 6 cycles; ihit first on cycle 7; no frame write before iwait=0.
- Address change mid-miss:
  - Stimulus: miss at 0x8, then imemaddr changes to 0x100 while iwait=1.
  - Required: the fill completes to 0x8 (iaddr stays 0x8); 0x100 then misses in IDLE; 0x8 later hits.
- Reset mid-miss:
  - Stimulus: nRST=0 during MISS.
  - Required: iREN=0 and ihit=0 immediately; after release, a fetch of the same address misses.
